// File: rtl/arm_data_path.sv
// Single-cycle LDR/STR datapath: PC, 16x32 register file, extender, ALU.
// Optional REG_RESET_EN: reset also clears register_file[0:14].
module arm_reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  addr1,
    input  logic [3:0]  addr2,
    input  logic [3:0]  addr3,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic [31:0] pc_plus8,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2
);

    logic [31:0] register_file [0:15];

    // R15 is the PC alias, so its array slot is never written or read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
`ifdef REG_RESET_EN
            for (int i = 0; i < 15; i++) begin
                register_file[i] <= '0;
            end
`endif
        end else if (we && addr3 != 4'hF) begin
            register_file[addr3] <= wd;
        end
    end

    assign read_data1 = (addr1 == 4'hF) ? pc_plus8 : register_file[addr1];
    assign read_data2 = (addr2 == 4'hF) ? pc_plus8 : register_file[addr2];

endmodule

module arm_data_path (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_src,
    input  logic        imm_src,
    input  logic        reg_write,
    input  logic [31:0] instr,
    input  logic [31:0] read_data,
    input  logic [1:0]  alu_ctl,
    output logic [31:0] pc,
    output logic [31:0] write_data,
    output logic [31:0] alu_result
);

    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic [31:0] pc_next;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] ext_imm;
    logic        unused_bits;

    assign pc_plus4 = pc + 32'd4;
    assign pc_plus8 = pc + 32'd8;
    assign pc_next  = pc_src ? read_data : pc_plus4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

    arm_reg_file register_file (
        .clk        (clk),
        .reset      (reset),
        .addr1      (instr[19:16]),
        .addr2      (instr[15:12]),
        .addr3      (instr[15:12]),
        .we         (reg_write),
        .wd         (read_data),
        .pc_plus8   (pc_plus8),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    assign ext_imm = imm_src ? {20'b0, instr[11:0]} : {24'b0, instr[7:0]};

    always_comb begin
        alu_result = '0;
        unique case (alu_ctl)
            2'b00: alu_result = read_data1 + ext_imm;
            2'b01: alu_result = read_data1 - ext_imm;
            2'b10: alu_result = read_data1 & ext_imm;
            2'b11: alu_result = read_data1 | ext_imm;
            default: alu_result = '0;
        endcase
    end

    assign write_data  = read_data2;
    assign unused_bits = ^instr[31:20];

endmodule

// File: tb/tb_arm_data_path.sv
// Directed vector bench for arm_data_path.
module tb_arm_data_path;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_src;
    logic        imm_src;
    logic        reg_write;
    logic [31:0] instr;
    logic [31:0] read_data;
    logic [1:0]  alu_ctl;
    logic [31:0] pc;
    logic [31:0] write_data;
    logic [31:0] alu_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arm_data_path dut (
        .clk        (clk),
        .reset      (reset),
        .pc_src     (pc_src),
        .imm_src    (imm_src),
        .reg_write  (reg_write),
        .instr      (instr),
        .read_data  (read_data),
        .alu_ctl    (alu_ctl),
        .pc         (pc),
        .write_data (write_data),
        .alu_result (alu_result)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rdata;
        logic        pc_src;
        logic        imm_src;
        logic        we;
        logic [1:0]  alu;
        logic [31:0] exp_pc;
        bit          c_wd;
        logic [31:0] exp_wd;
        bit          c_alu;
        logic [31:0] exp_alu;
    } vec_t;

    vec_t v [0:18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // instr, rdata, pc_src, imm_src, we, alu, pc, c_wd, wd, c_alu, alu
        v[0]  = '{32'hE5900000, 32'd3, 0, 1, 1, 2'b00, 32'd0, 0, 0, 0, 0};
        v[1]  = '{32'hE5901000, 32'd15, 0, 1, 1, 2'b00, 32'd4, 0, 0, 1, 32'd3};
        v[2]  = '{32'hE590B000, 32'd32, 0, 1, 1, 2'b00, 32'd8, 0, 0, 1, 32'd3};
        v[3]  = '{32'hE58B1000, 32'hDEAD, 0, 1, 0, 2'b00, 32'd12, 1, 32'd15, 1, 32'd32};
        v[4]  = '{32'hE58B1000, 32'hDEAD, 0, 1, 0, 2'b00, 32'd16, 1, 32'd15, 1, 32'd32};
        v[5]  = '{32'hE5900F05, 32'd0, 0, 0, 0, 2'b01, 32'd20, 1, 32'd3, 1, 32'hFFFFFFFE};
        v[6]  = '{32'hE5900F05, 32'd0, 0, 0, 0, 2'b10, 32'd24, 1, 32'd3, 1, 32'd1};
        v[7]  = '{32'hE5900F05, 32'd0, 0, 0, 0, 2'b11, 32'd28, 1, 32'd3, 1, 32'd7};
        v[8]  = '{32'hE5900F05, 32'd0, 0, 1, 0, 2'b00, 32'd32, 1, 32'd3, 1, 32'hF08};
        v[9]  = '{32'hE59FF000, 32'h55, 0, 1, 1, 2'b00, 32'd36, 1, 32'd44, 1, 32'd44};
        v[10] = '{32'hE58F0000, 32'd128, 1, 1, 0, 2'b00, 32'd40, 1, 32'd3, 1, 32'd48};
        v[11] = '{32'hE58F0000, 32'd0, 0, 1, 0, 2'b00, 32'd128, 1, 32'd3, 1, 32'd136};
        v[12] = '{32'hE5902000, 32'h200, 1, 1, 1, 2'b00, 32'd132, 0, 0, 1, 32'd3};
        v[13] = '{32'hE5922000, 32'd0, 0, 1, 0, 2'b00, 32'h200, 1, 32'h200, 1, 32'h200};
        v[14] = '{32'hE5911000, 32'd99, 0, 1, 1, 2'b00, 32'h204, 1, 32'd15, 1, 32'd15};
        v[15] = '{32'hE5911000, 32'd0, 0, 1, 0, 2'b00, 32'h208, 1, 32'd99, 1, 32'd99};
        v[16] = '{32'hE59F0000, 32'hFFFFFFFC, 1, 1, 0, 2'b00, 32'h20C, 1, 32'd3, 1, 32'h214};
        v[17] = '{32'hE59F0000, 32'd0, 0, 1, 0, 2'b00, 32'hFFFFFFFC, 1, 32'd3, 1, 32'd4};
        v[18] = '{32'hE59F0000, 32'd0, 0, 1, 0, 2'b00, 32'd0, 1, 32'd3, 1, 32'd8};

        reset     = 1'b0;
        pc_src    = 1'b0;
        imm_src   = 1'b1;
        reg_write = 1'b0;
        instr     = '0;
        read_data = '0;
        alu_ctl   = 2'b00;
        #1;
        chk("reset_pc", pc, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_pc_held", pc, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            instr     = v[i].instr;
            read_data = v[i].rdata;
            pc_src    = v[i].pc_src;
            imm_src   = v[i].imm_src;
            reg_write = v[i].we;
            alu_ctl   = v[i].alu;
            #1;
            chk($sformatf("v%0d_pc", i), pc, v[i].exp_pc);
            if (v[i].c_wd)
                chk($sformatf("v%0d_wd", i), write_data, v[i].exp_wd);
            if (v[i].c_alu)
                chk($sformatf("v%0d_alu", i), alu_result, v[i].exp_alu);
            @(negedge clk);
        end

        // pc is now 4; assert reset mid-cycle with a write pending to R1
        chk("pre_reset_pc", pc, 32'd4);
        instr     = 32'hE5911000;
        read_data = 32'h77;
        reg_write = 1'b1;
        pc_src    = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_pc", pc, 32'd0);
        @(negedge clk);
        chk("reset_hold_pc", pc, 32'd0);
        reg_write = 1'b0;
        reset     = 1'b1;
        #1;
        chk("post_reset_pc", pc, 32'd0);
`ifdef REG_RESET_EN
        chk("post_reset_r1", write_data, 32'd0);
        chk("post_reset_r0", alu_result, 32'd0);
`else
        chk("post_reset_r1", write_data, 32'd99);
        chk("post_reset_alu", alu_result, 32'd99);
`endif
        @(negedge clk);
        chk("post_reset_step", pc, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
